// File: rtl/upg_pkg.sv
// Shared constants and state encodings for the UART program loader and the upg_* bus.
package upg_pkg;

  localparam int UPG_ADDR_W  = 15;
  localparam int UPG_DATA_W  = 32;
  localparam int UPG_SEL_BIT = 14;  // 0 = program ROM, 1 = data RAM

  typedef logic [2:0] ld_state_t;
  typedef logic [1:0] rx_state_t;

  localparam logic [2:0] LD_WAIT   = 3'd0;
  localparam logic [2:0] LD_LEN_LO = 3'd1;
  localparam logic [2:0] LD_LEN_HI = 3'd2;
  localparam logic [2:0] LD_DATA   = 3'd3;
  localparam logic [2:0] LD_DONE   = 3'd4;
  localparam logic [2:0] LD_ERR    = 3'd5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  function automatic logic ld_is_busy(input ld_state_t s);
    return (s == LD_LEN_LO) || (s == LD_LEN_HI) || (s == LD_DATA);
  endfunction

endpackage

// File: rtl/upg_if.sv
// upg_* write bus between the loader and programrom/dmemory, plus FSM debug taps.
interface upg_if #(
  parameter int ADDR_W = upg_pkg::UPG_ADDR_W
);
  import upg_pkg::*;

  // No back-pressure: upg_wen_o is a one-cycle valid, the slave always accepts it
  // and must capture upg_adr_o/upg_dat_o in that same cycle.
  logic                  upg_wen_o;
  logic [ADDR_W-1:0]     upg_adr_o;
  logic [UPG_DATA_W-1:0] upg_dat_o;
  logic                  upg_done_o;
  logic                  upg_sel_ram;
  ld_state_t             dbg_ld_state;
  rx_state_t             dbg_rx_state;

  modport master (
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_sel_ram,
    output dbg_ld_state, dbg_rx_state
  );

  modport slave (
    input upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_sel_ram,
    input dbg_ld_state, dbg_rx_state
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      rx_i,
  output logic [7:0] byte_o,
  output logic      byte_valid_o,
  output logic      byte_err_o,
  output rx_state_t state_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check at the middle of the start bit to reject short glitches.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          err_d   = !sync2_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign byte_err_o   = err_q;
  assign state_o      = state_q;

endmodule

// File: rtl/uart_loader.sv
// UART image loader: length header, little-endian word packing, upg_* write strobes.
module uart_loader
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = UPG_ADDR_W
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   start,
  input  logic   rx,
  upg_if.master  upg,
  output logic   busy,
  output logic   frame_err
);

  logic      [7:0] rx_byte;
  logic            rx_valid;
  logic            rx_err;
  rx_state_t       rx_state;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clock),
    .rst_ni       (reset),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .byte_err_o   (rx_err),
    .state_o      (rx_state)
  );

  logic                  start_q;
  logic                  start_rise;
  ld_state_t             state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]     widx_q, widx_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           pack_q, pack_d;
  logic                  wen_q, wen_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [UPG_DATA_W-1:0] dat_q, dat_d;

  assign start_rise = start && !start_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    pack_d  = pack_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    // A new session wins over everything, including a byte arriving this cycle.
    if (start_rise) begin
      state_d = LD_LEN_LO;
      len_d   = '0;
      wcnt_d  = '0;
      widx_d  = '0;
      bidx_d  = '0;
      adr_d   = '0;
    end else if (rx_err && ld_is_busy(state_q)) begin
      state_d = LD_ERR;
      bidx_d  = '0;
    end else begin
      case (state_q)
        LD_LEN_LO: begin
          if (rx_valid) begin
            len_d[7:0] = rx_byte;
            state_d    = LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          if (rx_valid) begin
            len_d[15:8] = rx_byte;
            state_d     = ({rx_byte, len_q[7:0]} == 16'd0) ? LD_DONE : LD_DATA;
          end
        end
        LD_DATA: begin
          // Word index advances in the cycle after its strobe.
          if (wen_q) begin
            wcnt_d = wcnt_q + 16'd1;
            widx_d = widx_q + 1'b1;
            if ((wcnt_q + 16'd1) == len_q) state_d = LD_DONE;
          end
          if (rx_valid) begin
            if (bidx_q == 2'd3) begin
              wen_d  = 1'b1;
              dat_d  = {rx_byte, pack_q};
              adr_d  = widx_q;
              bidx_d = '0;
            end else begin
              pack_d = {rx_byte, pack_q[23:8]};
              bidx_d = bidx_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      state_q <= LD_WAIT;
      len_q   <= '0;
      wcnt_q  <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      pack_q  <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      start_q <= start;
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      pack_q  <= pack_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign upg.upg_wen_o    = wen_q;
  assign upg.upg_adr_o    = adr_q;
  assign upg.upg_dat_o    = dat_q;
  assign upg.upg_done_o   = (state_q == LD_DONE);
  assign upg.dbg_ld_state = state_q;
  assign upg.dbg_rx_state = rx_state;
  assign busy             = ld_is_busy(state_q);
  assign frame_err        = (state_q == LD_ERR);

  generate
    if (ADDR_W > UPG_SEL_BIT) begin : g_sel
      assign upg.upg_sel_ram = adr_q[UPG_SEL_BIT];
    end else begin : g_no_sel
      assign upg.upg_sel_ram = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table-driven sessions, random sessions, corner sequences.
module tb_uart_loader;
  import upg_pkg::*;

  localparam int CPB = 4;
  localparam int AW  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic rx    = 1'b1;
  logic busy;
  logic frame_err;

  upg_if #(.ADDR_W(AW)) bus ();

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rx        (rx),
    .upg       (bus.master),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int n_words;
    int n_data;
    int err_idx;
    bit exp_done;
    bit exp_ferr;
    bit exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];
  logic [7:0]     tx_q[$];
  bit             m_done, m_ferr, m_busy;
  bit             wen_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clock) begin
    logic [AW+31:0] e;
    if (bus.upg_wen_o === 1'b1) begin
      check("wen_one_cycle", {63'd0, wen_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual adr=%0h dat=%0h required none",
                 bus.upg_adr_o, bus.upg_dat_o);
      end else begin
        e = exp_q.pop_front();
        check("strobe_adr_dat", {bus.upg_adr_o, bus.upg_dat_o}, e);
      end
    end
    wen_prev = (bus.upg_wen_o === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input int gap);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (gap) @(negedge clock);
  endtask

  task automatic arm();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Reference: length header, then whole words taken only while no frame error has occurred.
  task automatic model_session(input int err_idx);
    int n;
    int need;
    logic [AW-1:0] a;
    n    = int'(tx_q[0]) + 256 * int'(tx_q[1]);
    need = 2 + 4 * n;
    m_ferr = (err_idx >= 0) && (err_idx < need);
    m_done = !m_ferr && (tx_q.size() >= need);
    m_busy = !m_ferr && !m_done;
    for (int w = 0; w < n; w++) begin
      int last;
      last = 2 + 4 * w + 3;
      if (last >= tx_q.size()) break;
      if (err_idx >= 0 && err_idx <= last) break;
      a = AW'(w);
      exp_q.push_back({a, tx_q[last], tx_q[last-1], tx_q[last-2], tx_q[last-3]});
    end
  endtask

  task automatic build_tx(input int n_words, input int n_data);
    tx_q.delete();
    tx_q.push_back(8'(n_words));
    tx_q.push_back(8'(n_words >> 8));
    for (int i = 0; i < n_data; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic run_session(input string tag, input int err_idx);
    arm();
    check({tag, "_arm_busy"}, {63'd0, busy}, 64'd1);
    check({tag, "_arm_ferr"}, {63'd0, frame_err}, 64'd0);
    check({tag, "_arm_done"}, {63'd0, bus.upg_done_o}, 64'd0);
    model_session(err_idx);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], (i != err_idx), CPB);
    repeat (3 * CPB) @(negedge clock);
    check({tag, "_done"}, {63'd0, bus.upg_done_o}, {63'd0, m_done});
    check({tag, "_ferr"}, {63'd0, frame_err}, {63'd0, m_ferr});
    check({tag, "_busy"}, {63'd0, busy}, {63'd0, m_busy});
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1, 4, -1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3, 12, -1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{0, 0, -1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2, 8, 3, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{10, 40, -1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{2, 4, -1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1, 4, 0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1, 6, -1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clock);
    check("rst_wen", {63'd0, bus.upg_wen_o}, 64'd0);
    check("rst_adr", 64'(bus.upg_adr_o), 64'd0);
    check("rst_dat", 64'(bus.upg_dat_o), 64'd0);
    check("rst_done", {63'd0, bus.upg_done_o}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ferr", {63'd0, frame_err}, 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Single word with exact strobe/done timing.
    arm();
    send_byte(8'h01, 1'b1, CPB);
    send_byte(8'h00, 1'b1, CPB);
    send_byte(8'hAA, 1'b1, CPB);
    send_byte(8'hBB, 1'b1, CPB);
    send_byte(8'hCC, 1'b1, CPB);
    exp_q.push_back({AW'(0), 32'hDDCCBBAA});
    send_byte(8'hDD, 1'b1, 0);
    @(negedge clock);
    check("t1_wen_early", {63'd0, bus.upg_wen_o}, 64'd0);
    @(negedge clock);
    check("t1_wen", {63'd0, bus.upg_wen_o}, 64'd1);
    check("t1_done_early", {63'd0, bus.upg_done_o}, 64'd0);
    @(negedge clock);
    check("t1_wen_off", {63'd0, bus.upg_wen_o}, 64'd0);
    check("t1_done", {63'd0, bus.upg_done_o}, 64'd1);
    check("t1_busy", {63'd0, busy}, 64'd0);
    check("t1_dat_hold", 64'(bus.upg_dat_o), 64'h00000000DDCCBBAA);
    check("t1_pending", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 8; i++) begin
      build_tx(tbl[i].n_words, tbl[i].n_data);
      run_session("tbl", tbl[i].err_idx);
      check("tbl_exp_done", {63'd0, bus.upg_done_o}, {63'd0, tbl[i].exp_done});
      check("tbl_exp_ferr", {63'd0, frame_err}, {63'd0, tbl[i].exp_ferr});
      check("tbl_exp_busy", {63'd0, busy}, {63'd0, tbl[i].exp_busy});
    end

    // One-cycle low glitch between the header and the data must not produce a byte.
    build_tx(1, 4);
    arm();
    model_session(-1);
    send_byte(tx_q[0], 1'b1, CPB);
    send_byte(tx_q[1], 1'b1, CPB);
    @(negedge clock);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    for (int i = 2; i < 6; i++) send_byte(tx_q[i], 1'b1, CPB);
    repeat (3 * CPB) @(negedge clock);
    check("glitch_done", {63'd0, bus.upg_done_o}, 64'd1);
    check("glitch_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Start edge coinciding with byte_valid drops that byte; start held high does not re-arm.
    send_byte(8'h55, 1'b1, 0);
    @(negedge clock);
    start = 1'b1;
    build_tx(1, 4);
    model_session(-1);
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 1'b1, CPB);
    repeat (3 * CPB) @(negedge clock);
    check("coinc_done", {63'd0, bus.upg_done_o}, 64'd1);
    check("coinc_busy", {63'd0, busy}, 64'd0);
    check("coinc_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clock);

    for (int r = 0; r < 6; r++) begin
      int n, extra, err;
      n     = $urandom_range(0, 3);
      extra = $urandom_range(0, 2);
      build_tx(n, 4 * n + extra);
      err = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1 + 4 * n + extra) : -1;
      run_session("rand", err);
    end

    // Reset in the middle of a word, then data without a start edge.
    arm();
    send_byte(8'h01, 1'b1, CPB);
    send_byte(8'h00, 1'b1, CPB);
    send_byte(8'h11, 1'b1, CPB);
    send_byte(8'h22, 1'b1, CPB);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_wen", {63'd0, bus.upg_wen_o}, 64'd0);
    check("mid_rst_adr", 64'(bus.upg_adr_o), 64'd0);
    check("mid_rst_dat", 64'(bus.upg_dat_o), 64'd0);
    check("mid_rst_done", {63'd0, bus.upg_done_o}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ferr", {63'd0, frame_err}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    send_byte(8'h33, 1'b1, CPB);
    send_byte(8'h44, 1'b1, CPB);
    send_byte(8'h55, 1'b1, CPB);
    send_byte(8'h66, 1'b1, CPB);
    repeat (3 * CPB) @(negedge clock);
    check("post_rst_done", {63'd0, bus.upg_done_o}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_dat", 64'(bus.upg_dat_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
